psum_post: RTL and testbench

PSUM_POST -- requirements
Module: psum_post

---
 rtl/psum_post.sv | 128 ++++++++++++
 tb/tb_psum_post.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_post.sv
// Partial-sum post-processing: per-lane accumulation across input channels, then
// requantization (shift + ReLU/signed saturation) and a lane-serial drain.
module psum_post #(
  parameter int unsigned LANES = 10,
  parameter int unsigned PW    = 22,
  parameter int unsigned ACCW  = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psum_valid,
  output logic                  psum_ready,
  input  logic [LANES*PW-1:0]   toPsum,
  input  logic                  ch_last,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [3:0]            out_lane,
  output logic                  out_last
);

  localparam int unsigned LW = 4;
  localparam logic signed [ACCW-1:0] UMAX = ACCW'(255);
  localparam logic signed [ACCW-1:0] SMAX = ACCW'(127);
  localparam logic signed [ACCW-1:0] SMIN = ACCW'(-128);

  // One-hot encoding so the handshake outputs come straight off a state flop.
  typedef enum logic [1:0] {
    ACC   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic signed [ACCW-1:0] acc_q  [LANES];
  logic signed [ACCW-1:0] sum_c  [LANES];
  logic        [7:0]      quant  [LANES];
  logic        [7:0]      bank_q [LANES];

  logic          xfer;
  logic          accept;
  logic          lane_end;
  logic [LW-1:0] lane_nxt;

  function automatic logic [7:0] requant(input logic signed [ACCW-1:0] s,
                                         input logic [4:0] sh,
                                         input logic relu);
    logic signed [ACCW-1:0] q;
    logic        [7:0]      r;
    q = s >>> sh;
    if (relu) begin
      if (q[ACCW-1])     r = 8'h00;
      else if (q > UMAX) r = 8'hFF;
      else               r = q[7:0];
    end else begin
      if (q > SMAX)      r = 8'h7F;
      else if (q < SMIN) r = 8'h80;
      else               r = q[7:0];
    end
    return r;
  endfunction

  assign xfer     = psum_valid && psum_ready;
  assign accept   = out_valid && out_ready;
  assign lane_end = (out_lane == LW'(LANES - 1));
  assign lane_nxt = out_lane + 4'd1;

  // Running sum per lane and its requantized value for a closing transfer.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_c[i] = acc_q[i] + ACCW'($signed(toPsum[i*PW +: PW]));
      quant[i] = requant(sum_c[i], shift, relu_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ACC;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (xfer && ch_last)    state_d = DRAIN;
      DRAIN:   if (accept && lane_end) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    psum_ready = (state_q == ACC);
    out_valid  = (state_q == DRAIN);
  end

  // Accumulators, output bank and the registered drain outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        acc_q[i]  <= '0;
        bank_q[i] <= '0;
      end
      out_data <= '0;
      out_lane <= '0;
      out_last <= 1'b0;
    end else begin
      if (xfer) begin
        for (int i = 0; i < LANES; i++) acc_q[i] <= ch_last ? '0 : sum_c[i];
      end
      if (xfer && ch_last) begin
        bank_q   <= quant;
        out_data <= quant[0];
        out_lane <= '0;
        out_last <= (LANES == 1);
      end else if (accept) begin
        if (lane_end) begin
          out_lane <= '0;
          out_last <= 1'b0;
        end else begin
          out_lane <= lane_nxt;
          out_data <= bank_q[lane_nxt];
          out_last <= (lane_nxt == LW'(LANES - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_post.sv
// Scoreboard bench for psum_post: a driver feeds tiles and queues expected beats from
// an arithmetic reference; a negedge monitor pops and compares every accepted beat.
module tb_psum_post;
  localparam int LANES = 10;
  localparam int PW    = 22;
  localparam int ACCW  = 28;

  logic                clk = 1'b0;
  logic                rst;
  logic                psum_valid;
  logic                psum_ready;
  logic [LANES*PW-1:0] to_psum;
  logic                ch_last;
  logic [4:0]          shift;
  logic                relu_en;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_data;
  logic [3:0]          out_lane;
  logic                out_last;

  psum_post #(.LANES(LANES), .PW(PW), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .toPsum(to_psum), .ch_last(ch_last), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         lane;
    bit         last;
  } exp_t;

  exp_t   expq[$];
  longint macc[LANES];
  int     lv[LANES];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact sum modulo 2^ACCW read as signed, floor-divide by 2^shift, clamp.
  function automatic longint wrap(input longint x);
    longint m;
    m = x & ((64'sd1 <<< ACCW) - 1);
    if (m >= (64'sd1 <<< (ACCW - 1))) m = m - (64'sd1 <<< ACCW);
    return m;
  endfunction

  function automatic logic [7:0] ref_q(input longint s, input int sh, input bit relu);
    longint q;
    logic [63:0] t;
    q = s >>> sh;
    if (relu) q = (q < 0) ? 0 : (q > 255) ? 255 : q;
    else      q = (q < -128) ? -128 : (q > 127) ? 127 : q;
    t = q;
    return t[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one transfer of lv[] and updates the reference model.
  task automatic xfer(input bit cl, input int sh, input bit rl);
    int n = 0;
    while (!psum_ready && n < 100) begin step(); n++; end
    if (!psum_ready) begin
      errors++;
      $display("FAIL xfer_wait: psum_ready stuck low got 0 expected 1");
      return;
    end
    for (int i = 0; i < LANES; i++) to_psum[i*PW +: PW] = PW'(lv[i]);
    ch_last = cl; shift = 5'(sh); relu_en = rl; psum_valid = 1'b1;
    step();
    psum_valid = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (cl) begin
        expq.push_back('{ref_q(wrap(macc[i] + longint'(lv[i])), sh, rl), i, i == LANES - 1});
        macc[i] = 0;
      end else begin
        macc[i] = wrap(macc[i] + longint'(lv[i]));
      end
    end
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (!(psum_ready && expq.size() == 0) && n < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(); n++;
    end
    out_ready = 1'b1;
    if (n >= 400) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", expq.size());
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < LANES; i++) lv[i] = v;
  endtask

  task automatic wait_lane(input int l);
    int n = 0;
    while (!(out_valid && out_lane == 4'(l)) && n < 50) begin step(); n++; end
    chk("wait_lane", longint'(out_lane), l);
  endtask

  // Monitor: compare accepted beats against the queue and check holds under stall.
  bit         stall_p = 1'b0;
  logic [7:0] d_p;
  logic [3:0] l_p;
  logic       last_p;
  always @(negedge clk) begin
    if (rst) begin
      if (stall_p && out_valid) begin
        chk("hold_data", out_data, d_p);
        chk("hold_lane", out_lane, l_p);
        chk("hold_last", out_last, last_p);
      end
      if (out_valid) begin
        chk("ready_in_drain", psum_ready, 0);
        if (out_ready) begin
          if (expq.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_beat: lane %0d data %0d expected none", out_lane, out_data);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_lane", out_lane, e.lane);
            chk("out_last", out_last, e.last);
          end
        end
      end
      stall_p = out_valid && !out_ready;
      d_p = out_data; l_p = out_lane; last_p = out_last;
    end else begin
      stall_p = 1'b0;
    end
  end

  initial begin
    int cyc;
    rst = 1'b0; psum_valid = 1'b0; to_psum = '0; ch_last = 1'b0;
    shift = '0; relu_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) macc[i] = 0;
    step(); step();
    rst = 1'b1;
    chk("rst_psum_ready", psum_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_out_last", out_last, 0);

    // Single tile, 300 >> 1 = 150, latency and drain length.
    fill(300);
    xfer(1, 1, 1);
    chk("latency_valid", out_valid, 1);
    chk("latency_lane", out_lane, 0);
    cyc = 0;
    while (!psum_ready && cyc < 50) begin step(); cyc++; end
    chk("drain_cycles", cyc, 10);

    // 3x100 saturates to 255, then 7 proves the accumulators cleared.
    fill(100);
    xfer(0, 0, 1); xfer(0, 0, 1); xfer(1, 0, 1);
    drain(0);
    fill(7); xfer(1, 0, 1); drain(0);

    // Negative values under both output modes.
    fill(-5);    xfer(1, 0, 1); drain(0);
    fill(-5);    xfer(1, 0, 0); drain(0);
    fill(-1000); xfer(1, 0, 0); drain(0);

    // Stall at lane 4 with psum_valid pulses that must be ignored.
    for (int i = 0; i < LANES; i++) lv[i] = int'($urandom_range(0, 4000)) - 2000;
    xfer(1, 2, 0);
    wait_lane(4);
    out_ready = 1'b0;
    fill(12345);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < LANES; i++) to_psum[i*PW +: PW] = PW'(lv[i]);
      ch_last = k[0]; psum_valid = 1'b1;
      step();
      chk("stall_ready", psum_ready, 0);
      chk("stall_lane", out_lane, 4);
    end
    psum_valid = 1'b0;
    drain(0);
    fill(11); xfer(1, 0, 0); drain(0);

    // Reset mid-drain at lane 6 discards the rest.
    fill(50); xfer(1, 0, 1);
    wait_lane(6);
    rst = 1'b0;
    step();
    expq.delete();
    rst = 1'b1;
    chk("rst_drain_valid", out_valid, 0);
    chk("rst_drain_ready", psum_ready, 1);
    fill(9); xfer(1, 0, 1); drain(0);

    // Exact 28-bit sums: 8 * (2^21-1) under several shifts.
    fill((1 << 21) - 1);
    for (int k = 0; k < 7; k++) xfer(0, 0, 1);
    xfer(1, 3, 1); drain(0);
    for (int k = 0; k < 7; k++) xfer(0, 0, 1);
    xfer(1, 17, 0); drain(0);
    for (int k = 0; k < 7; k++) xfer(0, 0, 1);
    xfer(1, 20, 0); drain(0);

    // Accumulator wraps past 2^27 into negative values.
    for (int k = 0; k < 80; k++) xfer(0, 0, 0);
    xfer(1, 20, 0); drain(0);

    // Randomized tiles with random back-pressure.
    for (int t = 0; t < 30; t++) begin
      int nx;
      nx = int'($urandom_range(0, 3));
      for (int k = 0; k <= nx; k++) begin
        for (int i = 0; i < LANES; i++)
          lv[i] = int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW - 1));
        xfer(k == nx, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end
      drain(1);
    end

    step(); step();
    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
